// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU datapath: sizes, ALU opcodes and
// the bus-source encoding with its fixed-priority select function.
package cpu_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int NSRC  = 27;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Strobe bit positions double as bus-source codes; 0..15 are R0..R15.
  typedef enum logic [4:0] {
    SRC_GPR    = 5'd0,
    SRC_HI     = 5'd16,
    SRC_LO,
    SRC_Y,
    SRC_ZHI,
    SRC_ZLO,
    SRC_PC,
    SRC_IR,
    SRC_MAR,
    SRC_MDR,
    SRC_INPORT,
    SRC_C,
    SRC_NONE
  } bus_src_e;

  // Lowest asserted strobe wins (R0 highest priority).
  function automatic bus_src_e bus_sel(input logic [NSRC-1:0] outs);
    bus_sel = SRC_NONE;
    for (int i = NSRC - 1; i >= 0; i--)
      if (outs[i]) bus_sel = bus_src_e'(5'(i));
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result {Zhigh, Zlow}.
// Multiply/divide exist only when MULDIV_EN is defined; otherwise those opcodes give 0.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [4:0]         i_opcode,
  input  logic               i_inc,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_ror, w_rol, w_lo, w_hi;

  assign w_sh  = i_b[SH_W-1:0];
  // A shift by WIDTH yields 0, so a zero rotate amount falls out naturally.
  assign w_ror = (i_a >> w_sh) | (i_a << (WIDTH - int'(w_sh)));
  assign w_rol = (i_a << w_sh) | (i_a >> (WIDTH - int'(w_sh)));

`ifdef MULDIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_a64, w_b64, w_prod;
  logic [WIDTH-1:0]          w_quo, w_rem;

  assign w_a64  = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_b64  = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod = w_a64 * w_b64;

  always_comb begin
    w_quo = '0;
    w_rem = '0;
    if (i_b == '0) begin
      w_quo = '1;
      w_rem = i_a;
    end else if (i_a == MIN_NEG && i_b == '1) begin
      // Overflowing quotient wraps; keep it explicit rather than rely on the divider.
      w_quo = MIN_NEG;
      w_rem = '0;
    end else begin
      w_quo = WIDTH'($signed(i_a) / $signed(i_b));
      w_rem = WIDTH'($signed(i_a) % $signed(i_b));
    end
  end
`endif

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    if (i_inc) begin
      w_lo = i_b + WIDTH'(1);
    end else begin
      case (i_opcode)
        OP_ADD:  w_lo = i_a + i_b;
        OP_SUB:  w_lo = i_a - i_b;
        OP_AND:  w_lo = i_a & i_b;
        OP_OR:   w_lo = i_a | i_b;
        OP_SHR:  w_lo = i_a >> w_sh;
        OP_SHRA: w_lo = $signed(i_a) >>> w_sh;
        OP_SHL:  w_lo = i_a << w_sh;
        OP_ROR:  w_lo = w_ror;
        OP_ROL:  w_lo = w_rol;
`ifdef MULDIV_EN
        OP_MUL:  {w_hi, w_lo} = w_prod;
        OP_DIV:  begin
          w_lo = w_quo;
          w_hi = w_rem;
        end
`endif
        OP_NEG:  w_lo = -i_b;
        OP_NOT:  w_lo = ~i_b;
        default: w_lo = '0;
      endcase
    end
  end

  assign o_result = {w_hi, w_lo};

endmodule

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Build with MULDIV_EN defined to include the signed multiplier and divider.
module cpu_datapath #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [4:0]       opcode,
  input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin,
  input  logic             MDRin, Inportin, Cin,
  input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
  input  logic             MDRout, Inportout, Cout,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [WIDTH-1:0] In_data,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] IR_q,
  output logic [WIDTH-1:0] MAR_q
);
  import cpu_pkg::*;

  logic [WIDTH-1:0]   r_gpr [NREGS];
  logic [WIDTH-1:0]   r_hi, r_lo, r_y, r_zhi, r_zlo, r_pc, r_ir, r_mar, r_mdr, r_inport, r_c;
  logic [NSRC-1:0]    w_in, w_out;
  bus_src_e           w_sel;
  logic [WIDTH-1:0]   w_bus;
  logic [2*WIDTH-1:0] w_alu;

  assign w_in  = {Cin, Inportin, MDRin, MARin, IRin, PCin, Zlowin, Zhighin, Yin, LOin, HIin,
                  R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign w_out = {Cout, Inportout, MDRout, MARout, IRout, PCout, Zlowout, Zhighout, Yout, LOout, HIout,
                  R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  assign w_sel = bus_sel(w_out);

  always_comb begin
    w_bus = '0;
    case (w_sel)
      SRC_HI:     w_bus = r_hi;
      SRC_LO:     w_bus = r_lo;
      SRC_Y:      w_bus = r_y;
      SRC_ZHI:    w_bus = r_zhi;
      SRC_ZLO:    w_bus = r_zlo;
      SRC_PC:     w_bus = r_pc;
      SRC_IR:     w_bus = r_ir;
      SRC_MAR:    w_bus = r_mar;
      SRC_MDR:    w_bus = r_mdr;
      SRC_INPORT: w_bus = r_inport;
      SRC_C:      w_bus = r_c;
      SRC_NONE:   w_bus = '0;
      default:    w_bus = r_gpr[w_sel[3:0]];
    endcase
  end

  cpu_alu u_alu (
    .i_a      (r_y),
    .i_b      (w_bus),
    .i_opcode (opcode),
    .i_inc    (IncPC),
    .o_result (w_alu)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_y      <= '0;
      r_zhi    <= '0;
      r_zlo    <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_inport <= '0;
      r_c      <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (w_in[i]) r_gpr[i] <= w_bus;
      if (w_in[SRC_HI])     r_hi     <= w_bus;
      if (w_in[SRC_LO])     r_lo     <= w_bus;
      if (w_in[SRC_Y])      r_y      <= w_bus;
      if (w_in[SRC_ZHI])    r_zhi    <= w_alu[2*WIDTH-1:WIDTH];
      if (w_in[SRC_ZLO])    r_zlo    <= w_alu[WIDTH-1:0];
      if (w_in[SRC_PC])     r_pc     <= w_bus;
      if (w_in[SRC_IR])     r_ir     <= w_bus;
      if (w_in[SRC_MAR])    r_mar    <= w_bus;
      if (w_in[SRC_MDR])    r_mdr    <= Read ? Mdatain : w_bus;
      if (w_in[SRC_INPORT]) r_inport <= In_data;
      // Immediate constant: sign-extended 19-bit field of the current IR.
      if (w_in[SRC_C])      r_c      <= {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};
    end
  end

  assign BusMuxOut = w_bus;
  assign IR_q      = r_ir;
  assign MAR_q     = r_mar;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed test-plan sequences plus
// randomized ALU and bus-priority stimulus against an arithmetic reference model.
module tb_cpu_datapath;

  localparam int IHI = 16, ILO = 17, IY = 18, IZH = 19, IZL = 20, IPC = 21;
  localparam int IIR = 22, IMAR = 23, IMDR = 24, IINP = 25, IC = 26;

  logic        Clock = 1'b0;
  logic        clear, Read, IncPC;
  logic [4:0]  opcode;
  logic [26:0] in_v, out_v;
  logic [31:0] Mdatain, In_data;
  wire  [31:0] BusMuxOut, IR_q, MAR_q;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [27];

  always #5 Clock = ~Clock;

  cpu_datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(in_v[0]),   .R1in(in_v[1]),   .R2in(in_v[2]),   .R3in(in_v[3]),
    .R4in(in_v[4]),   .R5in(in_v[5]),   .R6in(in_v[6]),   .R7in(in_v[7]),
    .R8in(in_v[8]),   .R9in(in_v[9]),   .R10in(in_v[10]), .R11in(in_v[11]),
    .R12in(in_v[12]), .R13in(in_v[13]), .R14in(in_v[14]), .R15in(in_v[15]),
    .HIin(in_v[16]), .LOin(in_v[17]), .Yin(in_v[18]), .Zhighin(in_v[19]), .Zlowin(in_v[20]),
    .PCin(in_v[21]), .IRin(in_v[22]), .MARin(in_v[23]), .MDRin(in_v[24]),
    .Inportin(in_v[25]), .Cin(in_v[26]),
    .R0out(out_v[0]),   .R1out(out_v[1]),   .R2out(out_v[2]),   .R3out(out_v[3]),
    .R4out(out_v[4]),   .R5out(out_v[5]),   .R6out(out_v[6]),   .R7out(out_v[7]),
    .R8out(out_v[8]),   .R9out(out_v[9]),   .R10out(out_v[10]), .R11out(out_v[11]),
    .R12out(out_v[12]), .R13out(out_v[13]), .R14out(out_v[14]), .R15out(out_v[15]),
    .HIout(out_v[16]), .LOout(out_v[17]), .Yout(out_v[18]), .Zhighout(out_v[19]), .Zlowout(out_v[20]),
    .PCout(out_v[21]), .IRout(out_v[22]), .MARout(out_v[23]), .MDRout(out_v[24]),
    .Inportout(out_v[25]), .Cout(out_v[26]),
    .Mdatain(Mdatain), .In_data(In_data),
    .BusMuxOut(BusMuxOut), .IR_q(IR_q), .MAR_q(MAR_q)
  );

  // Reference ALU built from the arithmetic definitions, not from bit slicing.
  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input bit inc);
    int          n  = int'(b % 32);
    longint      ua = longint'({32'h0, a});
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      p  = longint'(1) << n;
    longint      q;
    logic [31:0] ror;
    if (inc) return {32'h0, b + 32'd1};
    ror = 32'(ua / p) + 32'(ua * (longint'(1) << (32 - n)));
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  return {32'h0, 32'(ua / p)};
      5'd8: begin
        q = sa / p;
        if (sa < 0 && q * p != sa) q = q - 1;
        return {32'h0, 32'(q)};
      end
      5'd9:  return {32'h0, 32'(ua * p)};
      5'd10: return {32'h0, ror};
      5'd11: return {32'h0, 32'(ua * p) + 32'(ua / (longint'(1) << (32 - n)))};
`ifdef MULDIV_EN
      5'd15: return 64'(sa * sb);
      5'd16: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
`endif
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, 32'hFFFF_FFFF - b};
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] sext19(input logic [31:0] v);
    logic [31:0] c = v % 32'h80000;
    if (c >= 32'h40000) c = c + 32'hFFF8_0000;
    return c;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
    in_v = '0; out_v = '0; Read = 1'b0; IncPC = 1'b0; opcode = 5'd0; clear = 1'b0;
  endtask

  task automatic peek(input int idx, output logic [31:0] v);
    @(negedge Clock);
    out_v = 27'(1) << idx;
    #1;
    v = BusMuxOut;
    out_v = '0;
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    Mdatain = v; Read = 1'b1; in_v[IMDR] = 1'b1;
    tick();
    mdl[IMDR] = v;
    if (idx != IMDR) begin
      out_v[IMDR] = 1'b1; in_v[idx] = 1'b1;
      tick();
      mdl[idx] = v;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clear = 1'b1;
    tick();
    for (int i = 0; i < 27; i++) begin
      mdl[i] = 32'h0;
      peek(i, v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL reset_src%0d: got %h expected 00000000", i, v);
      end
    end
    @(negedge Clock);
    checks++;
    if (BusMuxOut !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle_bus: got %h expected 00000000", BusMuxOut);
    end
  endtask

  task automatic test_load_add();
    logic [31:0] v;
    load_reg(2, 32'h8);
    load_reg(3, 32'h9);
    out_v[2] = 1'b1; in_v[IY] = 1'b1; tick();
    out_v[3] = 1'b1; opcode = 5'b00011; in_v[IZL] = 1'b1; tick();
    out_v[IZL] = 1'b1; in_v[1] = 1'b1; tick();
    mdl[IY] = 32'h8; mdl[1] = 32'h11;
    peek(1, v);
    checks++;
    if (v !== 32'h11) begin
      failures++;
      $display("FAIL load_add_R1: got %h expected 00000011", v);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] v;
    out_v[IPC] = 1'b1; in_v[IMAR] = 1'b1; IncPC = 1'b1; in_v[IZL] = 1'b1; opcode = 5'b00101;
    tick();
    checks++;
    if (MAR_q !== 32'h0) begin
      failures++;
      $display("FAIL fetch_MAR: got %h expected 00000000", MAR_q);
    end
    peek(IZL, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL fetch_Zlow: got %h expected 00000001", v);
    end
    out_v[IZL] = 1'b1; in_v[IPC] = 1'b1; Read = 1'b1; in_v[IMDR] = 1'b1; Mdatain = 32'h1891_8000;
    tick();
    peek(IPC, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL fetch_PC: got %h expected 00000001", v);
    end
    peek(IMDR, v);
    checks++;
    if (v !== 32'h1891_8000) begin
      failures++;
      $display("FAIL fetch_MDR: got %h expected 18918000", v);
    end
    out_v[IMDR] = 1'b1; in_v[IIR] = 1'b1;
    tick();
    checks++;
    if (IR_q !== 32'h1891_8000) begin
      failures++;
      $display("FAIL fetch_IR: got %h expected 18918000", IR_q);
    end
  endtask

  task automatic test_const_inport();
    logic [31:0] irs [3];
    logic [31:0] v, d;
    irs = '{32'h1891_8000, 32'h0007_FFFF, 32'hABC4_0000};
    for (int k = 0; k < 3; k++) begin
      load_reg(IIR, irs[k]);
      in_v[IC] = 1'b1;
      tick();
      peek(IC, v);
      checks++;
      if (v !== sext19(irs[k])) begin
        failures++;
        $display("FAIL const_C ir=%h: got %h expected %h", irs[k], v, sext19(irs[k]));
      end
    end
    d = $urandom;
    In_data = d; in_v[IINP] = 1'b1; out_v[5] = 1'b1;
    tick();
    peek(IINP, v);
    checks++;
    if (v !== d) begin
      failures++;
      $display("FAIL inport: got %h expected %h", v, d);
    end
    // Read=0 path: MDR loads the bus value.
    load_reg(6, 32'h1234_5678);
    out_v[6] = 1'b1; in_v[IMDR] = 1'b1; Mdatain = 32'hDEAD_BEEF;
    tick();
    peek(IMDR, v);
    checks++;
    if (v !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mdr_from_bus: got %h expected 12345678", v);
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] hi, lo;
    logic [31:0] ya [3];
    logic [31:0] ba [3];
    logic [4:0]  oa [3];
    logic [63:0] ex [3];
    ya = '{32'hFFFF_FFFE, 32'h7, 32'h5};
    ba = '{32'h3, 32'hFFFF_FFFE, 32'h0};
    oa = '{5'b01111, 5'b10000, 5'b10000};
`ifdef MULDIV_EN
    ex = '{{32'hFFFF_FFFF, 32'hFFFF_FFFA}, {32'h1, 32'hFFFF_FFFD}, {32'h5, 32'hFFFF_FFFF}};
`else
    ex = '{64'h0, 64'h0, 64'h0};
`endif
    for (int k = 0; k < 3; k++) begin
      load_reg(IY, ya[k]);
      load_reg(7, ba[k]);
      out_v[7] = 1'b1; opcode = oa[k]; in_v[IZH] = 1'b1; in_v[IZL] = 1'b1;
      tick();
      peek(IZH, hi);
      peek(IZL, lo);
      checks++;
      if ({hi, lo} !== ex[k]) begin
        failures++;
        $display("FAIL muldiv_%0d: got %h expected %h", k, {hi, lo}, ex[k]);
      end
    end
  endtask

  task automatic test_random_alu();
    logic [4:0]  ops [15];
    logic [31:0] a, b, hi, lo;
    logic [4:0]  op;
    bit          inc;
    logic [63:0] ex;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
            5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd20};
    for (int k = 0; k < 80; k++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = b % 32'd32;
        1: b = 32'h0;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(0, 1) ? 32'd31 : 32'hFFFF_FFFF;
        default: ;
      endcase
      op  = ops[$urandom_range(0, 14)];
      inc = ($urandom_range(0, 7) == 0);
      load_reg(IY, a);
      load_reg(4, b);
      out_v[4] = 1'b1; opcode = op; IncPC = inc; in_v[IZH] = 1'b1; in_v[IZL] = 1'b1;
      tick();
      ex = ref_alu(a, b, op, inc);
      peek(IZH, hi);
      peek(IZL, lo);
      checks++;
      if ({hi, lo} !== ex) begin
        failures++;
        $display("FAIL alu op=%b inc=%0d a=%h b=%h: got %h expected %h", op, inc, a, b, {hi, lo}, ex);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v, z;
    load_reg(8, 32'hFFFF_FFFF);
    out_v[8] = 1'b1; IncPC = 1'b1; in_v[IZL] = 1'b1; in_v[IZH] = 1'b1;
    tick();
    peek(IZL, z);
    checks++;
    if (z !== 32'h0) begin
      failures++;
      $display("FAIL incpc_wrap: got %h expected 00000000", z);
    end
    // Zlow drives the bus and reloads with bus+1 in the same cycle.
    out_v[IZL] = 1'b1; IncPC = 1'b1; in_v[IZL] = 1'b1;
    tick();
    peek(IZL, v);
    checks++;
    if (v !== z + 32'd1) begin
      failures++;
      $display("FAIL z_self_inc: got %h expected %h", v, z + 32'd1);
    end
    // R9 drives the bus while R9 and HI load: both see the pre-edge value.
    load_reg(9, 32'hCAFE_0001);
    out_v[9] = 1'b1; in_v[9] = 1'b1; in_v[IHI] = 1'b1;
    tick();
    mdl[IHI] = 32'hCAFE_0001;
    peek(IHI, v);
    checks++;
    if (v !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL self_drive_load: got %h expected cafe0001", v);
    end
  endtask

  task automatic test_bus_priority();
    logic [26:0] m;
    logic [31:0] ex;
    load_reg(1, 32'hA);
    load_reg(5, 32'hB);
    @(negedge Clock);
    out_v = 27'h22;
    #1;
    checks++;
    if (BusMuxOut !== 32'hA) begin
      failures++;
      $display("FAIL prio_R1_R5: got %h expected 0000000a", BusMuxOut);
    end
    out_v = '0;
    #1;
    checks++;
    if (BusMuxOut !== 32'h0) begin
      failures++;
      $display("FAIL prio_none: got %h expected 00000000", BusMuxOut);
    end
    for (int i = 0; i < 18; i++) load_reg(i, $urandom);
    load_reg(IY, $urandom);
    for (int k = 0; k < 20; k++) begin
      m = 27'($urandom) & 27'h107_FFFF;
      m = m >> $urandom_range(0, 24);
      m = m & 27'h107_FFFF;
      ex = 32'h0;
      for (int i = 26; i >= 0; i--) if (m[i]) ex = mdl[i];
      @(negedge Clock);
      out_v = m;
      #1;
      checks++;
      if (BusMuxOut !== ex) begin
        failures++;
        $display("FAIL prio_rand mask=%h: got %h expected %h", m, BusMuxOut, ex);
      end
      out_v = '0;
    end
  endtask

  task automatic test_clear();
    logic [31:0] v;
    load_reg(6, 32'h5);
    load_reg(1, 32'h77);
    clear = 1'b1; out_v[6] = 1'b1; in_v[1] = 1'b1;
    tick();
    for (int i = 0; i < 27; i++) begin
      peek(i, v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL clear_src%0d: got %h expected 00000000", i, v);
      end
    end
    checks++;
    if (IR_q !== 32'h0 || MAR_q !== 32'h0) begin
      failures++;
      $display("FAIL clear_ports: got IR=%h MAR=%h expected 0", IR_q, MAR_q);
    end
  endtask

  initial begin
    in_v = '0; out_v = '0; Read = 1'b0; IncPC = 1'b0; opcode = 5'd0; clear = 1'b0;
    Mdatain = '0; In_data = '0;
    for (int i = 0; i < 27; i++) mdl[i] = 32'h0;
    @(negedge Clock);
    test_reset();
    test_load_add();
    test_fetch();
    test_const_inport();
    test_muldiv();
    test_random_alu();
    test_simultaneous();
    test_bus_priority();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
